// File: rtl/mem_access_pkg.sv
// Shared pipeline bundle types for the execute -> mem_access -> writeback path.
package mem_access_pkg;

    typedef struct packed {
        logic       mem_read;
        logic       mem_write;
        logic [2:0] funct3;
    } ctrl_t;

    typedef struct packed {
        logic        valid;
        logic [4:0]  rd;
        ctrl_t       ctrl;
        logic [31:0] alu;
        logic [31:0] rs2;
        logic [31:0] mdr;
    } stage_regs;

endpackage

// File: rtl/mem_access.sv
// Memory-access pipeline stage: issues data-memory requests, stalls until dmem_resp, aligns loads.
// Optional feature macro: MEM_MISALIGN_CHECK_EN (suppress misaligned accesses, pulse misalign).
module mem_access
    import mem_access_pkg::*;
#(
    parameter int unsigned width = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  stage_regs        in,
    output logic             stall,
    output logic             dmem_read,
    output logic             dmem_write,
    output logic [width-1:0] dmem_address,
    output logic [3:0]       dmem_byte_enable,
    output logic [width-1:0] dmem_wdata,
    input  logic [width-1:0] dmem_rdata,
    input  logic             dmem_resp,
`ifdef MEM_MISALIGN_CHECK_EN
    output logic             misalign,
`endif
    output stage_regs        regs
);

    typedef enum logic [0:0] {StIdle, StBusy} state_e;

    state_e           state_q, state_d;
    logic [1:0]       a;
    logic             mem_op;
    logic             is_load;
    logic [3:0]       store_be;
    logic [width-1:0] store_wdata;
    logic [width-1:0] rshift;
    logic [width-1:0] load_val;
    logic             issue;
    logic             done;
    stage_regs        regs_d;

    assign a       = in.alu[1:0];
    assign mem_op  = in.valid & (in.ctrl.mem_read | in.ctrl.mem_write);
    // Read wins when both strobes are set.
    assign is_load = in.ctrl.mem_read;
    assign rshift  = dmem_rdata >> {a, 3'b000};

    always_comb begin
        store_be    = 4'b0000;
        store_wdata = in.rs2;
        case (in.ctrl.funct3)
            3'b000: begin
                store_be    = 4'b0001 << a;
                store_wdata = in.rs2 << {a, 3'b000};
            end
            3'b001: begin
                store_be    = 4'b0011 << {a[1], 1'b0};
                store_wdata = in.rs2 << {a[1], 4'b0000};
            end
            3'b010: begin
                store_be    = 4'b1111;
                store_wdata = in.rs2;
            end
            default: store_be = 4'b0000;
        endcase
    end

    always_comb begin
        load_val = '0;
        case (in.ctrl.funct3)
            3'b000:  load_val = {{24{rshift[7]}}, rshift[7:0]};
            3'b001:  load_val = {{16{rshift[15]}}, rshift[15:0]};
            3'b010:  load_val = rshift;
            3'b100:  load_val = {24'b0, rshift[7:0]};
            3'b101:  load_val = {16'b0, rshift[15:0]};
            default: load_val = '0;
        endcase
    end

`ifdef MEM_MISALIGN_CHECK_EN
    logic misaligned;
    logic misalign_d;
    logic misalign_q;

    assign misaligned = ((in.ctrl.funct3[1:0] == 2'b01) & a[0]) |
                        ((in.ctrl.funct3[1:0] == 2'b10) & (a != 2'b00));
    assign misalign   = misalign_q;
`endif

    always_comb begin
        state_d    = state_q;
        stall      = 1'b0;
        issue      = 1'b0;
        done       = 1'b0;
        regs_d     = in;
        regs_d.mdr = '0;
`ifdef MEM_MISALIGN_CHECK_EN
        misalign_d = 1'b0;
`endif
        case (state_q)
            StIdle: begin
                if (mem_op) begin
                    regs_d.valid = 1'b0;
`ifdef MEM_MISALIGN_CHECK_EN
                    if (misaligned) begin
                        misalign_d = 1'b1;
                    end else begin
                        stall   = 1'b1;
                        issue   = 1'b1;
                        state_d = StBusy;
                    end
`else
                    stall   = 1'b1;
                    issue   = 1'b1;
                    state_d = StBusy;
`endif
                end
            end
            StBusy: begin
                if (dmem_resp) begin
                    done       = 1'b1;
                    state_d    = StIdle;
                    regs_d.mdr = is_load ? load_val : '0;
                end else begin
                    stall        = 1'b1;
                    regs_d.valid = 1'b0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q          <= StIdle;
            regs             <= '0;
            dmem_read        <= 1'b0;
            dmem_write       <= 1'b0;
            dmem_address     <= '0;
            dmem_byte_enable <= 4'b0000;
            dmem_wdata       <= '0;
        end else begin
            state_q <= state_d;
            regs    <= regs_d;
            if (issue) begin
                dmem_read        <= is_load;
                dmem_write       <= ~is_load;
                dmem_address     <= {in.alu[width-1:2], 2'b00};
                dmem_byte_enable <= is_load ? 4'b1111 : store_be;
                dmem_wdata       <= is_load ? '0 : store_wdata;
            end else if (done) begin
                dmem_read  <= 1'b0;
                dmem_write <= 1'b0;
            end
        end
    end

`ifdef MEM_MISALIGN_CHECK_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            misalign_q <= 1'b0;
        end else begin
            misalign_q <= misalign_d;
        end
    end
`endif

endmodule
